// File: rtl/pmem_ram_param.sv
// Writable, word-addressed instruction memory with a hardware NOP fill after reset and 1- or 2-cycle fetch latency.
// Optional storage parity is enabled by defining PMEM_PARITY_EN.
module pmem_ram_param #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 10,
  parameter int                DEPTH     = 2 ** (ADDR_W - 2),
  parameter int                LAT       = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] pc_read_c0,
  input  logic              stall,
  output logic [DATA_W-1:0] instr_q,
  output logic              instr_vld,
  output logic              fetch_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack,
  output logic              par_err
);

  localparam int IDX_W = ADDR_W - 2;
`ifdef PMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  if (LAT != 1 && LAT != 2) begin : g_bad_lat
    $error("pmem_ram_param: LAT must be 1 or 2");
  end

  // Handshake: a fetch is accepted when rd_en & fetch_ready & ~stall; a load
  // is committed when load_en & fetch_ready and acknowledged one cycle later.

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             init_we;

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [MEM_W-1:0]  mem_wword;

  logic              acc;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  src_word;
  logic              src_vld;
  logic              src_perr;

  logic [DATA_W-1:0] out_data_q;
  logic              out_vld_q;
  logic              out_perr_q;
  logic              load_ack_q;

  logic              unused_addr_lsbs;
  assign unused_addr_lsbs = ^{pc_read_c0[1:0], load_addr[1:0]};

  assign fetch_ready = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write port shared by the fill and the loader; no writes on a reset edge.
  always_comb begin
    mem_we    = rst_n & (init_we | (load_en & fetch_ready));
    mem_widx  = init_we ? cnt_q : load_addr[ADDR_W-1:2];
    mem_wdata = init_we ? INIT_WORD : load_data;
`ifdef PMEM_PARITY_EN
    mem_wword = {^mem_wdata, mem_wdata};
`else
    mem_wword = mem_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wword;
    end
  end

  // Read samples the array before the same-edge write lands, giving read-first.
  assign acc     = rd_en & fetch_ready & ~stall;
  assign rd_word = mem_q[pc_read_c0[ADDR_W-1:2]];

  if (LAT == 2) begin : g_lat2
    logic [MEM_W-1:0] s1_word_q;
    logic             s1_vld_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_word_q <= '0;
        s1_vld_q  <= 1'b0;
      end else if (!stall) begin
        s1_vld_q <= acc;
        if (acc) begin
          s1_word_q <= rd_word;
        end
      end
    end

    assign src_word = s1_word_q;
    assign src_vld  = s1_vld_q;
  end else begin : g_lat1
    assign src_word = rd_word;
    assign src_vld  = acc;
  end

`ifdef PMEM_PARITY_EN
  assign src_perr = src_vld & (^src_word);
`else
  assign src_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_perr_q <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      load_ack_q <= load_en & fetch_ready;
      if (!stall) begin
        out_vld_q  <= src_vld;
        out_perr_q <= src_perr;
        if (src_vld) begin
          out_data_q <= src_word[DATA_W-1:0];
        end
      end
    end
  end

  assign instr_q   = out_data_q;
  assign instr_vld = out_vld_q;
  assign par_err   = out_perr_q;
  assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_pmem_ram_param.sv
// Directed bench for pmem_ram_param: one LAT=1 and one LAT=2 instance share all inputs.
module tb_pmem_ram_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  pc = '0;
  logic        stall = 1'b0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  logic [31:0] q1, q2;
  logic        vld1, vld2, rdy1, rdy2, ack1, ack2, perr1, perr2;

  int checks = 0;
  int errors = 0;

`ifdef PMEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pmem_ram_param #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .pc_read_c0(pc), .stall(stall),
    .instr_q(q1), .instr_vld(vld1), .fetch_ready(rdy1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_ack(ack1), .par_err(perr1)
  );

  pmem_ram_param #(.LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .pc_read_c0(pc), .stall(stall),
    .instr_q(q2), .instr_vld(vld2), .fetch_ready(rdy2), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_ack(ack2), .par_err(perr2)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (q1 !== 32'h0 || q2 !== 32'h0) begin errors++; $display("FAIL reset_instr_q: got %h/%h expected 0", q1, q2); end
    checks++; if (vld1 !== 1'b0 || vld2 !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b/%b expected 0", vld1, vld2); end
    checks++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0", rdy1, rdy2); end
    checks++; if (ack1 !== 1'b0 || ack2 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b/%b expected 0", ack1, ack2); end
    checks++; if (perr1 !== 1'b0 || perr2 !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b/%b expected 0", perr1, perr2); end
  endtask

  // Requests held active through the fill must be ignored, including a load to 0x3FC.
  task automatic test_init();
    int n;
    rd_en     = 1'b1;
    pc        = 10'h3FC;
    load_en   = 1'b1;
    load_addr = 10'h3FC;
    load_data = 32'hBAD0BAD0;
    rst_n     = 1'b1;
    n = 0;
    while (!(rdy1 || rdy2) && n < 400) begin
      cyc();
      n++;
      checks++; if (vld1 !== 1'b0 || vld2 !== 1'b0) begin errors++; $display("FAIL init_no_vld: cycle %0d got %b/%b expected 0", n, vld1, vld2); end
      checks++; if (ack1 !== 1'b0 || ack2 !== 1'b0) begin errors++; $display("FAIL init_no_ack: cycle %0d got %b/%b expected 0", n, ack1, ack2); end
    end
    load_en = 1'b0;
    checks++; if (n != 256) begin errors++; $display("FAIL init_cycles: got %0d expected 256", n); end
    checks++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin errors++; $display("FAIL init_ready: got %b/%b expected 1", rdy1, rdy2); end
    cyc();
    rd_en = 1'b0;
    checks++; if (vld1 !== 1'b1 || q1 !== 32'h00000013) begin errors++; $display("FAIL init_fetch_lat1: got vld=%b q=%h expected vld=1 q=00000013", vld1, q1); end
    checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL init_fetch_lat2_early: got vld=%b expected 0", vld2); end
    cyc();
    checks++; if (vld2 !== 1'b1 || q2 !== 32'h00000013) begin errors++; $display("FAIL init_fetch_lat2: got vld=%b q=%h expected vld=1 q=00000013", vld2, q2); end
    checks++; if (vld1 !== 1'b0 || q1 !== 32'h00000013) begin errors++; $display("FAIL init_hold_lat1: got vld=%b q=%h expected vld=0 q=00000013", vld1, q1); end
    cyc();
  endtask

  task automatic test_load_fetch();
    load_en   = 1'b1;
    load_addr = 10'h010;
    load_data = 32'hDEADBEEF;
    cyc();
    load_en = 1'b0;
    checks++; if (ack1 !== 1'b1 || ack2 !== 1'b1) begin errors++; $display("FAIL load_ack: got %b/%b expected 1", ack1, ack2); end
    rd_en = 1'b1;
    pc    = 10'h010;
    cyc();
    checks++; if (ack1 !== 1'b0 || ack2 !== 1'b0) begin errors++; $display("FAIL load_ack_pulse: got %b/%b expected 0", ack1, ack2); end
    checks++; if (vld1 !== 1'b1 || q1 !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_010_lat1: got vld=%b q=%h expected vld=1 q=deadbeef", vld1, q1); end
    pc = 10'h011;
    cyc();
    rd_en = 1'b0;
    checks++; if (vld1 !== 1'b1 || q1 !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_011_lat1: got vld=%b q=%h expected vld=1 q=deadbeef", vld1, q1); end
    checks++; if (vld2 !== 1'b1 || q2 !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_010_lat2: got vld=%b q=%h expected vld=1 q=deadbeef", vld2, q2); end
    checks++; if (perr1 !== 1'b0 || perr2 !== 1'b0) begin errors++; $display("FAIL fetch_010_par: got %b/%b expected 0", perr1, perr2); end
    cyc();
    checks++; if (vld1 !== 1'b0 || q1 !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold_lat1: got vld=%b q=%h expected vld=0 q=deadbeef", vld1, q1); end
    checks++; if (vld2 !== 1'b1 || q2 !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_011_lat2: got vld=%b q=%h expected vld=1 q=deadbeef", vld2, q2); end
    cyc();
    checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL idle_lat2: got vld=%b expected 0", vld2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2;
    for (int i = 0; i < 3; i++) begin
      load_en   = 1'b1;
      load_addr = 10'(4 * i);
      load_data = 32'(i + 1);
      cyc();
      checks++; if (ack1 !== 1'b1 || ack2 !== 1'b1) begin errors++; $display("FAIL b2b_load_ack%0d: got %b/%b expected 1", i, ack1, ack2); end
    end
    load_en = 1'b0;
    cyc();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL b2b_ack_end: got %b expected 0", ack1); end
    for (int i = 0; i < 5; i++) begin
      rd_en = (i < 3);
      pc    = 10'(4 * i);
      cyc();
      e1 = (i < 3) ? 32'(i + 1) : 32'd3;
      checks++; if (vld1 !== (i < 3) || q1 !== e1) begin errors++; $display("FAIL b2b_lat1_%0d: got vld=%b q=%h expected vld=%b q=%h", i, vld1, q1, (i < 3), e1); end
      e2 = (i > 3) ? 32'd3 : 32'(i);
      checks++; if (vld2 !== (i >= 1 && i <= 3) || (i >= 1 && q2 !== e2)) begin
        errors++; $display("FAIL b2b_lat2_%0d: got vld=%b q=%h expected vld=%b q=%h", i, vld2, q2, (i >= 1 && i <= 3), e2);
      end
    end
  endtask

  task automatic test_stall();
    rd_en = 1'b1;
    pc    = 10'h000;
    cyc();
    pc = 10'h004;
    cyc();
    checks++; if (vld2 !== 1'b1 || q2 !== 32'd1) begin errors++; $display("FAIL stall_pre_lat2: got vld=%b q=%h expected vld=1 q=1", vld2, q2); end
    stall = 1'b1;
    pc    = 10'h008;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (vld2 !== 1'b1 || q2 !== 32'd1) begin errors++; $display("FAIL stall_hold_lat2_%0d: got vld=%b q=%h expected vld=1 q=1", i, vld2, q2); end
      checks++; if (vld1 !== 1'b1 || q1 !== 32'd2) begin errors++; $display("FAIL stall_hold_lat1_%0d: got vld=%b q=%h expected vld=1 q=2", i, vld1, q1); end
    end
    stall = 1'b0;
    cyc();
    rd_en = 1'b0;
    checks++; if (vld2 !== 1'b1 || q2 !== 32'd2) begin errors++; $display("FAIL stall_out2_lat2: got vld=%b q=%h expected vld=1 q=2", vld2, q2); end
    checks++; if (vld1 !== 1'b1 || q1 !== 32'd3) begin errors++; $display("FAIL stall_out3_lat1: got vld=%b q=%h expected vld=1 q=3", vld1, q1); end
    cyc();
    checks++; if (vld2 !== 1'b1 || q2 !== 32'd3) begin errors++; $display("FAIL stall_out3_lat2: got vld=%b q=%h expected vld=1 q=3", vld2, q2); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL stall_drain_lat1: got vld=%b expected 0", vld1); end
    cyc();
    checks++; if (vld2 !== 1'b0 || q2 !== 32'd3) begin errors++; $display("FAIL stall_drain_lat2: got vld=%b q=%h expected vld=0 q=3", vld2, q2); end
  endtask

  task automatic test_collision();
    load_en   = 1'b1;
    load_addr = 10'h020;
    load_data = 32'h12345678;
    rd_en     = 1'b1;
    pc        = 10'h020;
    cyc();
    load_en = 1'b0;
    checks++; if (vld1 !== 1'b1 || q1 !== 32'h00000013) begin errors++; $display("FAIL coll_old_lat1: got vld=%b q=%h expected vld=1 q=00000013", vld1, q1); end
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL coll_ack: got %b expected 1", ack1); end
    cyc();
    rd_en = 1'b0;
    checks++; if (q1 !== 32'h12345678) begin errors++; $display("FAIL coll_new_lat1: got %h expected 12345678", q1); end
    checks++; if (vld2 !== 1'b1 || q2 !== 32'h00000013) begin errors++; $display("FAIL coll_old_lat2: got vld=%b q=%h expected vld=1 q=00000013", vld2, q2); end
    cyc();
    checks++; if (vld2 !== 1'b1 || q2 !== 32'h12345678) begin errors++; $display("FAIL coll_new_lat2: got vld=%b q=%h expected vld=1 q=12345678", vld2, q2); end
    cyc();
  endtask

  task automatic test_reset_run();
    int n;
    rd_en = 1'b1;
    pc    = 10'h020;
    cyc();
    rst_n = 1'b0;
    cyc();
    checks++; if (vld1 !== 1'b0 || vld2 !== 1'b0) begin errors++; $display("FAIL rrun_vld: got %b/%b expected 0", vld1, vld2); end
    checks++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin errors++; $display("FAIL rrun_ready: got %b/%b expected 0", rdy1, rdy2); end
    checks++; if (q1 !== 32'h0) begin errors++; $display("FAIL rrun_q: got %h expected 0", q1); end
    rst_n = 1'b1;
    rd_en = 1'b0;
    n = 0;
    while (!rdy1 && n < 400) begin
      cyc();
      n++;
    end
    checks++; if (n != 256) begin errors++; $display("FAIL rrun_init_cycles: got %0d expected 256", n); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    checks++; if (vld1 !== 1'b1 || q1 !== 32'h00000013) begin errors++; $display("FAIL rrun_refill_lat1: got vld=%b q=%h expected vld=1 q=00000013", vld1, q1); end
    cyc();
    checks++; if (vld2 !== 1'b1 || q2 !== 32'h00000013) begin errors++; $display("FAIL rrun_refill_lat2: got vld=%b q=%h expected vld=1 q=00000013", vld2, q2); end
    cyc();
  endtask

  // With parity enabled, one stored bit of word 0x040 is flipped directly in both arrays.
  task automatic test_parity();
`ifdef PMEM_PARITY_EN
    dut1.mem_q[16] = dut1.mem_q[16] ^ 33'h1;
    dut2.mem_q[16] = dut2.mem_q[16] ^ 33'h1;
`endif
    rd_en = 1'b1;
    pc    = 10'h040;
    cyc();
    checks++; if (vld1 !== 1'b1 || perr1 !== PAR_ON) begin errors++; $display("FAIL par_040_lat1: got vld=%b perr=%b expected vld=1 perr=%b", vld1, perr1, PAR_ON); end
    pc = 10'h044;
    cyc();
    rd_en = 1'b0;
    checks++; if (perr1 !== 1'b0) begin errors++; $display("FAIL par_044_lat1: got %b expected 0", perr1); end
    checks++; if (vld2 !== 1'b1 || perr2 !== PAR_ON) begin errors++; $display("FAIL par_040_lat2: got vld=%b perr=%b expected vld=1 perr=%b", vld2, perr2, PAR_ON); end
    cyc();
    checks++; if (vld2 !== 1'b1 || perr2 !== 1'b0) begin errors++; $display("FAIL par_044_lat2: got vld=%b perr=%b expected vld=1 perr=0", vld2, perr2); end
    cyc();
    checks++; if (perr1 !== 1'b0 || perr2 !== 1'b0) begin errors++; $display("FAIL par_idle: got %b/%b expected 0", perr1, perr2); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_load_fetch();
    test_back_to_back();
    test_stall();
    test_collision();
    test_reset_run();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem_ram_param.md
Name: pmem_ram_param

Overview:
- Parametrised, writable successor to the fixed 256x32 program ROM.
- Word-addressed instruction memory with configurable data width, address width and read latency (1 or 2 cycles).
- After reset it runs a hardware fill that sets every word to a NOP. A load port then lets a boot master write program words.
- Sits between the core fetch stage (byte PC in, instruction out) and the boot/debug loader.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 10, byte-address width. Word index is pc[ADDR_W-1:2].
- DEPTH, 2**(ADDR_W-2), number of words.
- LAT, 1, read latency in cycles. Legal values are 1 and 2; any other value is a compile-time error.
- INIT_WORD, 32'h00000013, fill value written during INIT (RV32I NOP).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- rd_en  in  1  fetch request this cycle.
- pc_read_c0  in  ADDR_W  fetch byte address. Bits [1:0] are ignored.
- stall  in  1  holds the read pipeline and outputs.
- instr_q  out  DATA_W  fetched instruction.
- instr_vld  out  1  instr_q carries data for an accepted fetch.
- fetch_ready  out  1  memory is in RUN and accepts fetches.
- load_en  in  1  write request.
- load_addr  in  ADDR_W  write byte address. Bits [1:0] are ignored.
- load_data  in  DATA_W  write data.
- load_ack  out  1  one-cycle pulse: previous-cycle write was committed.
- par_err  out  1  parity error flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to INIT and fill counter to 0.
  - instr_q=0, instr_vld=0, load_ack=0, fetch_ready=0, par_err=0, all pipeline valid bits=0.
  - Memory contents are not cleared by reset itself; the INIT fill overwrites them.
- State INIT:
  - Each cycle, writes INIT_WORD to word[cnt] and increments cnt.
  - When cnt==DEPTH-1 is written, the next state is RUN. The fill takes exactly DEPTH cycles.
  - rd_en and load_en are ignored: no instr_vld, no load_ack.
- State RUN:
  - fetch_ready=1. The state remains RUN until reset.
  - Reset asserted mid-INIT or mid-RUN restarts INIT from cnt=0 and discards in-flight reads.
- Fetch accept: acc = rd_en & fetch_ready & ~stall.
  - LAT=1: instr_q and instr_vld update at the first edge after acc.
  - LAT=2: stage-1 register at the first edge, output register at the second edge.
  - Not accepted and not stalled: instr_vld=0 next cycle, and instr_q holds its last value.
- Stall:
  - While stall=1, instr_q, instr_vld and all internal stage registers hold.
  - rd_en is not accepted; upstream keeps pc_read_c0 and rd_en stable.
- Load:
  - When load_en & fetch_ready, word[load_addr[ADDR_W-1:2]] is written at the edge.
  - load_ack=1 in the following cycle only.
  - Loads are independent of stall. One write per cycle is allowed, back-to-back.
- Same-word read and write in the same cycle: read-first. The fetch returns the old word; the next fetch returns the new word.
- Address wrap: the word index is truncated to ADDR_W-2 bits. No out-of-range detection is performed.

Optional Feature:
- Macro: PMEM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity over the data. It is generated on load writes and INIT writes.
  - On read, parity is recomputed and compared. par_err is asserted in the same cycle and alignment as instr_vld, qualified by instr_vld.
  - par_err holds under stall.
- Undefined:
  - Storage is DATA_W bits and par_err is constant 0.

Test Plan:
- INIT timing, DEPTH=256: release rst_n -> fetch_ready rises exactly 256 cycles later. A fetch at 0x3FC returns 32'h00000013 with instr_vld.
- Load then fetch, LAT=1: load 0x010 <= 32'hDEADBEEF -> load_ack next cycle. Fetch 0x010 -> instr_q=32'hDEADBEEF one cycle later. Fetch 0x011 returns the same word.
- LAT=2 pipelined fetches: back-to-back fetches 0x000, 0x004, 0x008 after loading 1, 2, 3 -> instr_q=1, 2, 3 on cycles +2, +3, +4 with instr_vld continuous.
- Stall mid-stream, LAT=2: stall=1 for 3 cycles with two reads in flight -> instr_q/instr_vld frozen, then values 2 and 3 emerge in order with no loss or duplication.
- Collisions: same-cycle load 0x020 <= 32'h12345678 and fetch 0x020 -> old value 32'h00000013 returned; the next fetch returns 32'h12345678. Reset asserted during RUN -> instr_vld=0, fetch_ready=0, and after INIT word 0x020 reads 32'h00000013.
- PMEM_PARITY_EN: force-flip one stored bit of word 0x040 via bench backdoor -> fetch gives par_err=1 with instr_vld. Fetches of untouched words give par_err=0.
